stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the cycle and instruction counters.
REQ-002 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have port run_mode  input  1: 1 = continuous execution, 0 = single-step.
REQ-005 SHALL have port step  input  1: single-step release request, sampled as a level in S_HOLD.
REQ-006 SHALL have ports IF_over, ID_over, EXE_over, MEM_over, WB_over  input  1 each: the named stage has completed its work.
REQ-007 SHALL have ports IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid  output  1 each: the named stage owns the current instruction.
REQ-008 SHALL have ports IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en  output  1 each: load enables for the inter-stage bus registers.
REQ-009 SHALL have port next_fetch  output  1: single-cycle pulse telling the PC to advance (sequential or jbr target).
REQ-010 SHALL have port state  output  3: current FSM state code, for display.
REQ-011 SHALL have port cycle_cnt  output  CNT_W: free-running cycle count.
REQ-012 SHALL have port inst_cnt  output  CNT_W: retired-instruction count.

Function
REQ-013 SHALL implement a registered FSM with codes S_IDLE=0, S_IF=1, S_ID=2, S_EXE=3, S_MEM=4, S_WB=5, S_HOLD=6; code 7 is illegal.
REQ-014 SHALL move S_IDLE -> S_IF unconditionally on the first cycle after reset is released.
REQ-015 SHALL drive each X_valid as a decode of state (exactly one high in S_IF..S_WB, all low in S_IDLE/S_HOLD), with no combinational path from any *_over input.
REQ-016 SHALL advance S_IF->S_ID, S_ID->S_EXE, S_EXE->S_MEM and S_MEM->S_WB on the clock edge at which the current stage's X_over=1; otherwise the state SHALL hold.
REQ-017 SHALL assert the matching bus-register enable combinationally (IF_ID_en = IF_valid & IF_over, and likewise for the other three) for exactly the cycle of the advance.
REQ-018 SHALL, in S_WB with WB_over=1, pulse next_fetch for that one cycle, increment inst_cnt, then go to S_IF if run_mode=1, else to S_HOLD.
REQ-019 SHALL, in S_HOLD, go to S_IF when step=1 or run_mode=1; a step held high SHALL release exactly one instruction per visit to S_HOLD.
REQ-020 SHALL ignore any X_over whose stage is not valid (no advance, no enable).
REQ-021 SHALL give a minimum of 5 cycles per instruction (one per stage) when each X_over is high in the first cycle its stage is valid.
REQ-022 SHALL increment cycle_cnt every cycle in which rst=0.
REQ-023 SHALL let both counters wrap modulo 2^CNT_W with no saturation or flag.
REQ-024 SHALL recover from the illegal state 7 to S_IF on the next edge, with all outputs low that cycle.
REQ-025 SHALL follow run_mode changes mid-instruction only at the next WB completion or S_HOLD.

Reset
REQ-026 SHALL, with rst=1 at an edge, set state=S_IDLE and cycle_cnt=inst_cnt=0, so that every valid, enable and next_fetch output is 0; this holds from any state.
REQ-027 SHALL let rst take priority over every *_over input, step and run_mode in the same cycle, and SHALL give no retire credit to an instruction in flight.

Structure
REQ-028 SHALL place the state codes S_IDLE..S_HOLD and the state width (3) in a shared CPU package, together with the stage index constants.
REQ-029 SHALL instantiate a sub-module event_counter (parameter CNT_W; inputs clk, rst, inc; output count) twice: cycle_cnt with inc=1, inst_cnt with inc=WB_valid&WB_over.

Verification
REQ-030 SHALL cover: rst for 2 cycles, then run_mode=1 with all *_over tied to 1 -> state 0,1,2,3,4,5,1,..., next_fetch every 5th cycle, inst_cnt=4 after 20 cycles past S_IDLE.
REQ-031 SHALL cover: EXE_over held low 3 cycles in S_EXE -> state stays 3 for 4 cycles, EXE_MEM_en high only on the 4th, cycles per instruction = 8.
REQ-032 SHALL cover: run_mode=0 -> after WB the FSM parks in state 6; a one-cycle step pulse -> exactly one instruction retires (inst_cnt +1), then back in state 6.
REQ-033 SHALL cover: rst asserted in S_MEM with MEM_over=1 -> no MEM_WB_en and no next_fetch; next state 0; inst_cnt and cycle_cnt = 0.
REQ-034 SHALL cover: stray pulses on IF_over and WB_over while in S_ID -> no state change and no enable or next_fetch pulse.
REQ-035 SHALL cover: CNT_W=4 with continuous run -> inst_cnt wraps 15 -> 0 at the 16th retirement and cycle_cnt wraps every 16 cycles.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: shared state codes and stage indices for the multi-cycle CPU sequencer
package stage_sequencer_pkg;
  localparam int STATE_W = 3;
  localparam int N_STAGES = 5;
  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB = 4;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HOLD = 3'd6
  } state_e;
endpackage

// File: rtl/stage_sequencer_event_counter.sv
// event_counter: wrapping event counter cleared by synchronous reset
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;
  // count qualifying cycles, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else if (inc) count_q <= count_q + 1'b1;
  end
  assign count = count_q;
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: one-instruction-at-a-time IF/ID/EXE/MEM/WB sequencer with single-step support
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_mode,
  input  logic               step,
  input  logic               IF_over,
  input  logic               ID_over,
  input  logic               EXE_over,
  input  logic               MEM_over,
  input  logic               WB_over,
  output logic               IF_valid,
  output logic               ID_valid,
  output logic               EXE_valid,
  output logic               MEM_valid,
  output logic               WB_valid,
  output logic               IF_ID_en,
  output logic               ID_EXE_en,
  output logic               EXE_MEM_en,
  output logic               MEM_WB_en,
  output logic               next_fetch,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   inst_cnt
);
  state_e state_q, state_d;
  logic [N_STAGES-1:0] valid, over, done;
  logic advance;
  assign over = {WB_over, MEM_over, EXE_over, ID_over, IF_over};
  assign valid = (state_q >= S_IF && state_q <= S_WB) ? N_STAGES'(1) << (state_q - S_IF) : '0;
  assign done = valid & over;
  assign advance = |done;
  assign {WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid} = valid;
  assign {MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en} = rst ? 4'b0 : done[STG_MEM:STG_IF];
  assign next_fetch = !rst && done[STG_WB];
  assign state = state_q;
  // state register; reset parks the sequencer in idle and drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // next state: a stage advances only on its own completion; illegal codes restart fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:                     state_d = S_IF;
      S_IF, S_ID, S_EXE, S_MEM:   state_d = advance ? state_e'(state_q + 3'd1) : state_q;
      S_WB:                       state_d = advance ? (run_mode ? S_IF : S_HOLD) : S_WB;
      S_HOLD:                     state_d = (step || run_mode) ? S_IF : S_HOLD;
      default:                    state_d = S_IF;
    endcase
  end
  event_counter #(.CNT_W(CNT_W)) u_cycle_cnt (.clk(clk), .rst(rst), .inc(1'b1), .count(cycle_cnt));
  event_counter #(.CNT_W(CNT_W)) u_inst_cnt (.clk(clk), .rst(rst), .inc(done[STG_WB]), .count(inst_cnt));
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed and random checks of stage_sequencer against a stage-position model
module tb_stage_sequencer;
  logic clk = 1'b0;
  logic rst, run_mode, step;
  logic [4:0] ov;
  logic [4:0] vld, vld4;
  logic [3:0] en, en4;
  logic nf, nf4;
  logic [2:0] st, st4;
  logic [31:0] cyc, inst;
  logic [3:0] cyc4, inst4;
  int n_assert = 0;
  int n_fail = 0;
  int m_st;
  logic [31:0] m_cyc, m_inst, saved;

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step(step),
    .IF_over(ov[0]), .ID_over(ov[1]), .EXE_over(ov[2]), .MEM_over(ov[3]), .WB_over(ov[4]),
    .IF_valid(vld[0]), .ID_valid(vld[1]), .EXE_valid(vld[2]), .MEM_valid(vld[3]), .WB_valid(vld[4]),
    .IF_ID_en(en[0]), .ID_EXE_en(en[1]), .EXE_MEM_en(en[2]), .MEM_WB_en(en[3]),
    .next_fetch(nf), .state(st), .cycle_cnt(cyc), .inst_cnt(inst)
  );

  stage_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step(step),
    .IF_over(ov[0]), .ID_over(ov[1]), .EXE_over(ov[2]), .MEM_over(ov[3]), .WB_over(ov[4]),
    .IF_valid(vld4[0]), .ID_valid(vld4[1]), .EXE_valid(vld4[2]), .MEM_valid(vld4[3]), .WB_valid(vld4[4]),
    .IF_ID_en(en4[0]), .ID_EXE_en(en4[1]), .EXE_MEM_en(en4[2]), .MEM_WB_en(en4[3]),
    .next_fetch(nf4), .state(st4), .cycle_cnt(cyc4), .inst_cnt(inst4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check mid-cycle outputs against the model, then step the model at the edge
  task automatic tick();
    logic [4:0] v_e;
    logic [3:0] en_e;
    logic nf_e;
    #4;
    v_e = (m_st >= 1 && m_st <= 5) ? 5'(1 << (m_st - 1)) : 5'b0;
    en_e = rst ? 4'b0 : v_e[3:0] & ov[3:0];
    nf_e = !rst && v_e[4] && ov[4];
    chk("state", {29'b0, st}, m_st);
    chk("valid", {27'b0, vld}, {27'b0, v_e});
    chk("enable", {28'b0, en}, {28'b0, en_e});
    chk("next_fetch", {31'b0, nf}, {31'b0, nf_e});
    chk("cycle_cnt", cyc, m_cyc);
    chk("inst_cnt", inst, m_inst);
    chk("state4", {29'b0, st4}, m_st);
    chk("enable4", {27'b0, nf4, en4}, {27'b0, nf_e, en_e});
    chk("cycle_cnt4", {28'b0, cyc4}, {28'b0, m_cyc[3:0]});
    chk("inst_cnt4", {28'b0, inst4}, {28'b0, m_inst[3:0]});
    @(posedge clk);
    if (rst) begin
      m_st = 0;
      m_cyc = 0;
      m_inst = 0;
    end else begin
      m_cyc++;
      if (m_st == 0) m_st = 1;
      else if (m_st >= 1 && m_st <= 4) m_st = ov[m_st-1] ? m_st + 1 : m_st;
      else if (m_st == 5) begin
        if (ov[4]) begin
          m_inst++;
          m_st = run_mode ? 1 : 6;
        end
      end else if (m_st == 6 && (step || run_mode)) m_st = 1;
    end
    #1;
  endtask

  task automatic run_to(input int target, input int budget);
    int k = 0;
    while (m_st != target && k < budget) begin
      tick();
      k++;
    end
    chk("reach_state", m_st, target);
  endtask

  initial begin
    rst = 1'b1;
    run_mode = 1'b1;
    step = 1'b0;
    ov = 5'h1F;
    @(posedge clk);
    #1;
    m_st = 0;
    m_cyc = 0;
    m_inst = 0;
    tick();
    rst = 1'b0;
    repeat (21) tick();
    chk("inst_after_20", inst, 32'd4);
    run_to(3, 10);
    ov[2] = 1'b0;
    repeat (3) tick();
    ov[2] = 1'b1;
    tick();
    run_to(1, 10);
    run_mode = 1'b0;
    run_to(6, 20);
    repeat (3) tick();
    chk("parked", {29'b0, st}, 32'd6);
    saved = m_inst;
    step = 1'b1;
    tick();
    step = 1'b0;
    run_to(6, 20);
    chk("step_one", inst, saved + 1);
    step = 1'b1;
    repeat (18) tick();
    step = 1'b0;
    run_mode = 1'b1;
    run_to(2, 20);
    ov = 5'b10001;
    repeat (3) tick();
    ov = 5'h1F;
    run_to(4, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_state", {29'b0, st}, 32'd0);
    chk("rst_cyc", cyc, 32'd0);
    chk("rst_inst", inst, 32'd0);
    repeat (81) tick();
    chk("inst_wrap4", {28'b0, inst4}, 32'd0);
    chk("inst_16", inst, 32'd16);
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 5; b++) ov[b] = ($urandom_range(9) < 6);
      if ($urandom_range(19) == 0) run_mode = $urandom_range(1);
      step = ($urandom_range(3) == 0);
      rst = ($urandom_range(149) == 0);
      tick();
    end
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
